// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for a combinational 16-bit ALU: takes one request at a time, screens domain
// errors, holds operands steady while the ALU settles, then returns the captured result with an error code.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FACT_MAX      = 12,
  parameter int unsigned EXP_MAX       = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_FACT = 4'd10;
  localparam logic [3:0] OP_EXP  = 4'd11;
  localparam logic [3:0] OP_LAST = 4'd11;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] out_result_q, out_result_d;
  logic [1:0]  out_err_q, out_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic [1:0]  chk_err;
  logic        fact_zero;
  logic        narrow_op;

  // Domain screening on the latched request, in priority order.
  always_comb begin
    chk_err = ERR_OK;
    if (op_q > OP_LAST) begin
      chk_err = ERR_ILLEGAL;
    end else if (op_q == OP_DIV && b_q == 16'd0) begin
      chk_err = ERR_DIV0;
    end else if ((op_q == OP_FACT && {16'd0, a_q} > FACT_MAX) ||
                 (op_q == OP_EXP  && {16'd0, a_q} > EXP_MAX)) begin
      chk_err = ERR_RANGE;
    end
  end

  assign fact_zero = (op_q == OP_FACT) && (a_q == 16'd0);
  // Logic, shift, add/sub and div results are 16 bits wide; only MUL/FACT/EXP use the upper half.
  assign narrow_op = (alu_op_q <= OP_SUB) || (alu_op_q == OP_DIV);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    cnt_d        = cnt_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    err_count_d  = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (chk_err != ERR_OK) begin
          out_result_d = 32'd0;
          out_err_d    = chk_err;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
          state_d = S_DONE;
        end else if (fact_zero) begin
          out_result_d = 32'd1;
          out_err_d    = ERR_OK;
          state_d      = S_DONE;
        end else begin
          alu_op_d = op_q;
          alu_a_d  = a_q;
          alu_b_d  = b_q;
          cnt_d    = SETTLE_LOAD;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          out_result_d = narrow_op ? {16'd0, alu_result[15:0]} : alu_result;
          out_err_d    = ERR_OK;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 4'd0;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      alu_op_q     <= 4'd0;
      alu_a_q      <= 16'd0;
      alu_b_q      <= 16'd0;
      cnt_q        <= 8'd0;
      out_result_q <= 32'd0;
      out_err_q    <= ERR_OK;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      cnt_q        <= cnt_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer, with a combinational ALU stand-in and a
// request-level reference model.
module tb_alu_op_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [1:0]  out_err;
  logic        busy;
  logic [7:0]  err_count;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_errcnt = 8'd0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .FACT_MAX(12), .EXP_MAX(22)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
    .busy(busy), .err_count(err_count)
  );

  function automatic logic [31:0] fact32(input logic [15:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  function automatic logic [31:0] exp32(input logic [15:0] n);
    longint v;
    v = longint'($exp(real'(n)));
    return v[31:0];
  endfunction

  // ALU stand-in: junk in the upper half of 16-bit results, and no result for FACT(0).
  always_comb begin
    alu_result = 32'hDEAD_0000;
    case (alu_op)
      4'd0:  alu_result = {16'hBEEF, alu_a | alu_b};
      4'd1:  alu_result = {16'hBEEF, alu_a & alu_b};
      4'd2:  alu_result = {16'hBEEF, ~alu_a};
      4'd3:  alu_result = {16'hBEEF, alu_a ^ alu_b};
      4'd4:  alu_result = {16'hBEEF, alu_a << 1};
      4'd5:  alu_result = {16'hBEEF, alu_a >> 1};
      4'd6:  alu_result = {16'hBEEF, alu_a + alu_b};
      4'd7:  alu_result = {16'hBEEF, alu_a - alu_b};
      4'd8:  alu_result = 32'(alu_a) * 32'(alu_b);
      4'd9:  alu_result = (alu_b == 16'd0) ? 32'hFFFF_FFFF : {16'hBEEF, alu_a / alu_b};
      4'd10: alu_result = (alu_a == 16'd0 || alu_a > 16'd12) ? 32'd0 : fact32(alu_a);
      4'd11: alu_result = (alu_a > 16'd22) ? 32'd0 : exp32(alu_a);
      default: alu_result = 32'hDEAD_0000;
    endcase
  end

  // Expected outcome of one request straight from the operator rules.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] res, output logic [1:0] err, output bit via_alu);
    logic [15:0] t;
    res = 32'd0; err = 2'd0; via_alu = 1'b0; t = 16'd0;
    if (op >= 4'd12)                                      err = 2'd3;
    else if (op == 4'd9 && b == 16'd0)                    err = 2'd1;
    else if ((op == 4'd10 && a > 16'd12) || (op == 4'd11 && a > 16'd22)) err = 2'd2;
    else if (op == 4'd10 && a == 16'd0)                   res = 32'd1;
    else begin
      via_alu = 1'b1;
      case (op)
        4'd0: t = a | b;
        4'd1: t = a & b;
        4'd2: t = ~a;
        4'd3: t = a ^ b;
        4'd4: t = a << 1;
        4'd5: t = a >> 1;
        4'd6: t = a + b;
        4'd7: t = a - b;
        4'd9: t = a / b;
        default: t = 16'd0;
      endcase
      res = {16'd0, t};
      if (op == 4'd8)  res = 32'(a) * 32'(b);
      if (op == 4'd10) res = fact32(a);
      if (op == 4'd11) res = exp32(a);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int stall);
    logic [31:0] er;
    logic [1:0]  ee;
    bit          ua;
    logic [3:0]  pop;
    logic [15:0] pa, pb;
    int          edges;
    model(op, a, b, er, ee, ua);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    edges = 0;
    while (!in_ready && edges < 50) begin @(negedge clk); edges++; end
    check("accept_ready", 32'(in_ready), 32'd1);
    pop = alu_op; pa = alu_a; pb = alu_b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
    edges = 0;
    while (!out_valid && edges < 50) begin @(posedge clk); #1; edges++; end
    $display("[TB] op=%0d a=%0d b=%0d -> result=0x%08h err=%0d after %0d cycles",
             op, a, b, out_result, out_err, edges);
    check("latency", 32'(edges), ua ? 32'(SETTLE + 1) : 32'd1);
    check("result", out_result, er);
    check("err", 32'(out_err), 32'(ee));
    if (ee != 2'd0 && exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
    check("err_count", 32'(err_count), 32'(exp_errcnt));
    check("alu_op", 32'(alu_op), ua ? 32'(op) : 32'(pop));
    check("alu_a", 32'(alu_a), ua ? 32'(a) : 32'(pa));
    check("alu_b", 32'(alu_b), ua ? 32'(b) : 32'(pb));
    check("done_busy", 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_op = 4'd6; in_a = 16'd1; in_b = 16'd1;
      check("stall_inready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", out_result, er);
      check("stall_err", 32'(out_err), 32'(ee));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_inready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    bit          saw_valid;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_inready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Directed operator cases
    run_txn(4'd6, 16'd3080, 16'd756, 0);
    run_txn(4'd9, 16'd100, 16'd0, 0);
    run_txn(4'd10, 16'd12, 16'd0, 0);
    run_txn(4'd10, 16'd13, 16'd0, 0);
    run_txn(4'd10, 16'd0, 16'd0, 0);
    run_txn(4'd8, 16'd3080, 16'd756, 0);
    run_txn(4'd7, 16'd1, 16'd2, 0);
    run_txn(4'd14, 16'd5, 16'd6, 0);
    run_txn(4'd11, 16'd22, 16'd0, 0);
    run_txn(4'd11, 16'd23, 16'd0, 0);
    run_txn(4'd4, 16'h8001, 16'd0, 0);
    run_txn(4'd6, 16'hFFFF, 16'd2, 5);
    run_txn(4'd3, 16'h1234, 16'hFF00, 0);

    // Reset in the middle of WAIT aborts the request
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd6; in_a = 16'd10; in_b = 16'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_inready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_errcnt = 8'd0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", out_result, 32'd0);
    check("midrst_err", 32'(out_err), 32'd0);
    check("midrst_alu", {12'd0, alu_op, alu_a}, 32'd0);
    check("midrst_alu_b", 32'(alu_b), 32'd0);
    check("midrst_errcnt", 32'(err_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    saw_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
    check("midrst_no_valid", 32'(saw_valid), 32'd0);
    run_txn(4'd6, 16'd3080, 16'd756, 0);

    // Randomized requests with domain-edge bias
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (rop == 4'd9 && $urandom_range(0, 2) == 0) rb = 16'd0;
      if (rop == 4'd10) ra = 16'($urandom_range(0, 14));
      if (rop == 4'd11) ra = 16'($urandom_range(0, 24));
      run_txn(rop, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
